// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The stage is the master; the memory acknowledges with variable latency.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory access FSM, MEM/WB register, forwarding selects.
// Latency: one cycle per register; memory access completes in the dmem_ack cycle.
// Backpressure: stall holds the front end while a memory access waits; MEM_TIMEOUT_EN forces completion.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  EX_MEM_OpCode_in,
    input  logic [31:0] PC_plus4_in,
    input  logic [31:0] ALUout_in,
    input  logic [31:0] Write_Data_in,
    input  logic [4:0]  RegWriteDst_in,
    input  logic [4:0]  Rs_ex,
    input  logic [4:0]  Rt_ex,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic [31:0] ALUout_prev,
    output logic [31:0] MemtoReg,
    output logic [1:0]  DataSrc1,
    output logic [1:0]  DataSrc2,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_Dst,
    output logic [31:0] WB_Data,
    output logic        bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    state_t      state_q, state_d;
    logic        ex_rd_q, ex_wr_q, ex_rw_q;
    logic [1:0]  ex_sel_q;
    logic [31:0] ex_pc4_q, ex_alu_q, ex_wd_q;
    logic [4:0]  ex_dst_q;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mem_op;
    logic        timeout_hit;
    logic [31:0] rd_data;
    logic        ex_fwd_ok, wb_fwd_ok;
    logic        unused_bits;

    assign mem_op = ex_rd_q | ex_wr_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q;

    // cnt_q counts stalled cycles of the current access, including the first IDLE one
    assign timeout_hit = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_q | timeout_hit;
        end
    end

    assign bus_err     = bus_err_q;
    assign unused_bits = EX_MEM_OpCode_in[0];
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
    assign unused_bits = EX_MEM_OpCode_in[0] ^ (^TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op && !dmem.dmem_ack) begin
                    state_d = WAIT;
                    stall   = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end
            end
            WAIT: begin
                if (dmem.dmem_ack || timeout_hit) begin
                    state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    stall   = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_data = timeout_hit ? 32'h0 : dmem.dmem_rdata;

    // Stores never return memory data, so WB select 01 on a store still writes ALUout
    always_comb begin
        wb_we_d   = 1'b0;
        wb_dst_d  = 5'd0;
        wb_data_d = 32'h0;
        if (!stall) begin
            wb_we_d  = ex_rw_q;
            wb_dst_d = ex_dst_q;
            if (ex_sel_q == SEL_PC4)
                wb_data_d = ex_pc4_q;
            else if (ex_sel_q == SEL_MEM && !ex_wr_q)
                wb_data_d = rd_data;
            else
                wb_data_d = ex_alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ex_rd_q   <= 1'b0;
            ex_wr_q   <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_sel_q  <= 2'b00;
            ex_pc4_q  <= 32'h0;
            ex_alu_q  <= 32'h0;
            ex_wd_q   <= 32'h0;
            ex_dst_q  <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= 5'd0;
            wb_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                ex_rd_q  <= EX_MEM_OpCode_in[5];
                ex_wr_q  <= EX_MEM_OpCode_in[4];
                ex_rw_q  <= EX_MEM_OpCode_in[3];
                ex_sel_q <= EX_MEM_OpCode_in[2:1];
                ex_pc4_q <= PC_plus4_in;
                ex_alu_q <= ALUout_in;
                ex_wd_q  <= Write_Data_in;
                ex_dst_q <= RegWriteDst_in;
            end
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign dmem.dmem_req   = mem_op;
    assign dmem.dmem_we    = ex_wr_q;
    assign dmem.dmem_addr  = ex_alu_q;
    assign dmem.dmem_wdata = ex_wd_q;

    assign ALUout_prev = (ex_sel_q == SEL_PC4) ? ex_pc4_q : ex_alu_q;
    assign MemtoReg    = wb_data_q;
    assign WB_RegWrite = wb_we_q;
    assign WB_Dst      = wb_dst_q;
    assign WB_Data     = wb_data_q;

    // A load sitting in EX/MEM has no result yet, so it is never an EX/MEM forward source
    assign ex_fwd_ok = ex_rw_q && (ex_dst_q != 5'd0) && (ex_sel_q != SEL_MEM);
    assign wb_fwd_ok = wb_we_q && (wb_dst_q != 5'd0);

    assign DataSrc1 = (ex_fwd_ok && ex_dst_q == Rs_ex) ? 2'b10 :
                      (wb_fwd_ok && wb_dst_q == Rs_ex) ? 2'b01 : 2'b00;
    assign DataSrc2 = (ex_fwd_ok && ex_dst_q == Rt_ex) ? 2'b10 :
                      (wb_fwd_ok && wb_dst_q == Rt_ex) ? 2'b01 : 2'b00;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX stage output interface.
- Contains the EX/MEM pipeline register, the data-memory access controller (req/ack handshake, variable latency), the MEM/WB pipeline register and the forwarding-select logic.
- Returns ALUout_prev, MemtoReg and DataSrc1/DataSrc2 to EX.
- Asserts stall to freeze the front of the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles spent waiting for dmem_ack. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- EX_MEM_OpCode_in  input  6  control bits: [5] MemRead, [4] MemWrite, [3] RegWrite, [2:1] WB select (00 ALU, 01 mem, 10 PC+4, 11 treated as 00), [0] ignored
- PC_plus4_in  input  32  PC+4 of the instruction leaving EX
- ALUout_in  input  32  ALU result / memory address
- Write_Data_in  input  32  store data (already forwarded)
- RegWriteDst_in  input  5  destination register
- Rs_ex  input  5  Rs of the instruction currently in EX
- Rt_ex  input  5  Rt of the instruction currently in EX
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  byte address
- dmem_wdata  output  32  write data
- dmem_ack  input  1  memory completion
- dmem_rdata  input  32  read data; valid only while dmem_ack=1
- stall  output  1  hold IF/ID/EX and the EX/MEM register
- ALUout_prev  output  32  EX/MEM forward value
- MemtoReg  output  32  MEM/WB forward value (equals WB_Data)
- DataSrc1  output  2  forward select for Rs: 10 EX/MEM, 01 MEM/WB, 00 none
- DataSrc2  output  2  forward select for Rt, same encoding
- WB_RegWrite  output  1  register-file write enable
- WB_Dst  output  5  register-file write address
- WB_Data  output  32  register-file write data
- bus_err  output  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset (reset=0 at a clock edge):
  - EX/MEM and MEM/WB registers cleared; FSM goes to IDLE; timeout counter cleared; bus_err cleared.
  - All outputs are 0 after reset, including dmem_req, stall and DataSrc*.
  - Reset overrides stall, ack and any in-flight access. An access abandoned by reset is not reissued.
- EX/MEM register:
  - Loads all *_in ports on each edge while stall=0.
  - Holds its contents while stall=1.
- Memory op definition: mem_op = MemRead | MemWrite of the EX/MEM register. If both bits are set, it is a write (MemWrite wins).
- Memory outputs:
  - dmem_req = mem_op while the FSM is in IDLE or WAIT.
  - dmem_we = MemWrite; dmem_addr = EX/MEM ALUout; dmem_wdata = EX/MEM Write_Data.
  - All of these stay stable until the ack cycle.
- FSM, states IDLE and WAIT:
  - IDLE, mem_op=1, dmem_ack=0: go to WAIT; stall=1.
  - IDLE, mem_op=1, dmem_ack=1: access completes this cycle (zero-wait); stall=0.
  - WAIT, dmem_ack=0: stay in WAIT; stall=1.
  - WAIT, dmem_ack=1: complete; go to IDLE; stall=0 this cycle.
  - dmem_ack while mem_op=0 is ignored.
  - stall = mem_op & ~dmem_ack (combinational).
- MEM/WB register, updated every edge:
  - If stall=1, load a bubble: RegWrite=0, Dst=0, Data=0.
  - Otherwise load RegWrite, Dst and Data, where Data is selected by WB select: 00 → ALUout, 01 → dmem_rdata (captured in the ack cycle), 10 → PC+4.
  - A store with RegWrite=1 writes ALUout.
- Forward values:
  - ALUout_prev = EX/MEM PC+4 if WB select = 10, else EX/MEM ALUout.
  - MemtoReg = WB_Data.
- DataSrc1, Rs side (DataSrc2 identical using Rt_ex):
  - 10 if EX/MEM RegWrite, EX/MEM dst≠0, dst==Rs_ex and WB select≠01.
  - Else 01 if WB_RegWrite, WB_Dst≠0 and WB_Dst==Rs_ex.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
  - A load in EX/MEM is never forwarded from EX/MEM; the load-use stall belongs to the hazard unit.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter (width from TIMEOUT) counts cycles spent in WAIT.
  - If the count reaches TIMEOUT with no ack, the access is force-completed: read data = 32'h0, stall drops that cycle, FSM returns to IDLE, bus_err is set.
  - bus_err stays set until reset.
- Undefined: no counter; WAIT persists indefinitely; bus_err tied to 0.

Test Plan:
- Reset mid-WAIT (load pending, ack withheld, reset=0 for one edge) → next cycle dmem_req=0, stall=0, WB_RegWrite=0, DataSrc1=00.
- ALU op RegWrite=1, dst=5, ALUout=0x1234; next instr Rs_ex=5 → DataSrc1=10, ALUout_prev=0x1234. One cycle later with Rt_ex=5 → DataSrc2=01, MemtoReg=0x1234.
- Load from addr 0x40 with ack after 3 cycles, rdata=0xCAFEF00D → stall=1 for exactly 3 cycles, dmem_addr stable at 0x40, bubbles in MEM/WB. Then WB_Data=0xCAFEF00D, WB_Dst correct.
- Store with ack in the same cycle as request → stall never asserted; dmem_we=1, dmem_wdata matches; WB_RegWrite=0.
- dst=0 with RegWrite=1 and Rs_ex=0 → DataSrc1=00. Both stages targeting r7, Rs_ex=7 → DataSrc1=10.
- MEM_TIMEOUT_EN, TIMEOUT=4, ack never given → stall high for 4 cycles, then drops; bus_err=1; WB_Data=0 for a load.
